// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin arbiter for the shared write port of the async
//               FIFO. Define FIFO_ARB_LOCK_EN to add bounded burst locking.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NREQ-1:0]          req_lock,
`endif
    input  logic                     wfull,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DWIDTH-1:0]        wdata,
    output logic                     burst
);

    localparam int c_PW = $clog2(NREQ);

    logic [c_PW-1:0] r_rr_ptr;
    logic [c_PW-1:0] w_idx;
    logic            w_hit;
    logic [c_PW-1:0] w_sel_idx;
    logic            w_sel_vld;
    logic            w_winc;
    int              w_j;

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(r_rr_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!w_hit && req[w_j]) begin
                w_hit = 1'b1;
                w_idx = c_PW'(w_j);
            end
        end
    end

    // Reset and full both suppress the write combinationally.
    assign w_winc = w_sel_vld & ~wfull & ~rst;
    assign winc   = w_winc;
    assign wdata  = w_winc ? req_data[w_sel_idx*DWIDTH +: DWIDTH] : '0;

    always_comb begin
        gnt = '0;
        if (w_winc) begin
            gnt[w_sel_idx] = 1'b1;
        end
    end

`ifdef FIFO_ARB_LOCK_EN
    localparam int c_BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_PW-1:0] r_owner;
    logic [c_BW-1:0] r_bcnt;
    logic            r_burst;

    assign w_sel_idx = (r_state == S_BURST) ? r_owner : w_idx;
    assign w_sel_vld = (r_state == S_BURST) ? req[r_owner] : w_hit;
    assign burst     = r_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_bcnt   <= '0;
            r_burst  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_winc) begin
                        if (req_lock[w_idx]) begin
                            r_state <= S_BURST;
                            r_owner <= w_idx;
                            r_bcnt  <= c_BW'(1);
                            r_burst <= 1'b1;
                        end else begin
                            r_rr_ptr <= f_inc(w_idx);
                        end
                    end
                end
                S_BURST: begin
                    // While full, owner and count simply hold.
                    if (!wfull) begin
                        if (req[r_owner]) begin
                            r_bcnt <= r_bcnt + 1'b1;
                            if (!req_lock[r_owner] || (r_bcnt == c_BW'(MAX_BURST - 1))) begin
                                r_state  <= S_IDLE;
                                r_burst  <= 1'b0;
                                r_rr_ptr <= f_inc(r_owner);
                            end
                        end else begin
                            r_state  <= S_IDLE;
                            r_burst  <= 1'b0;
                            r_rr_ptr <= f_inc(r_owner);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_burst <= 1'b0;
                end
            endcase
        end
    end
`else
    assign w_sel_idx = w_idx;
    assign w_sel_vld = w_hit;
    assign burst     = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_winc) begin
            r_rr_ptr <= f_inc(w_idx);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed self-checking bench for fifo_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_lock;
    logic                   wfull;
    logic [NREQ-1:0]        gnt;
    logic                   winc;
    logic [DWIDTH-1:0]      wdata;
    logic                   burst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef FIFO_ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .wfull    (wfull),
        .gnt      (gnt),
        .winc     (winc),
        .wdata    (wdata),
        .burst    (burst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic look(input string tag, input logic [NREQ-1:0] e_gnt,
                        input logic [DWIDTH-1:0] e_data, input logic e_burst);
        #2;
        chk({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        chk({tag, ".winc"},  32'(winc),  32'(|e_gnt));
        chk({tag, ".wdata"}, 32'(wdata), 32'(e_data));
        chk({tag, ".burst"}, 32'(burst), 32'(e_burst));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        req_lock = 4'b0000;
        wfull    = 1'b0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(posedge clk);
        #1;

        // Outputs forced to zero during reset even with requests pending
        look("reset", 4'b0000, 8'h00, 1'b0);
        rst = 1'b0;

        // Round-robin from reset
        look("rr0", 4'b0001, 8'hA0, 1'b0);
        look("rr1", 4'b0010, 8'hA1, 1'b0);
        look("rr2", 4'b0100, 8'hA2, 1'b0);
        look("rr3", 4'b1000, 8'hA3, 1'b0);
        look("rr4", 4'b0001, 8'hA0, 1'b0);

        // No requests: pointer (now 1) holds
        req = 4'b0000;
        look("idle0", 4'b0000, 8'h00, 1'b0);
        look("idle1", 4'b0000, 8'h00, 1'b0);
        req = 4'b1111;
        look("idle_resume", 4'b0010, 8'hA1, 1'b0);

        // Full back-pressure from pointer 0
        do_reset();
        req   = 4'b0101;
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            look("full", 4'b0000, 8'h00, 1'b0);
        end
        wfull = 1'b0;
        look("full_rel0", 4'b0001, 8'hA0, 1'b0);
        look("full_rel1", 4'b0100, 8'hA2, 1'b0);
        look("full_rel2", 4'b0001, 8'hA0, 1'b0);

`ifdef FIFO_ARB_LOCK_EN
        // Full-length locked burst by requester 1
        do_reset();
        req      = 4'b1111;
        req_lock = 4'b0010;
        look("lk_pre", 4'b0001, 8'hA0, 1'b0);
        look("lk_w1",  4'b0010, 8'hA1, 1'b0);
        for (int w = 2; w <= 8; w++) begin
            look("lk_w", 4'b0010, 8'hA1, 1'b1);
        end
        look("lk_next", 4'b0100, 8'hA2, 1'b0);

        // Owner drops req after 3 words
        do_reset();
        req      = 4'b0010;
        req_lock = 4'b0010;
        look("ee_w1", 4'b0010, 8'hA1, 1'b0);
        look("ee_w2", 4'b0010, 8'hA1, 1'b1);
        look("ee_w3", 4'b0010, 8'hA1, 1'b1);
        req = 4'b1101;
        look("ee_drop", 4'b0000, 8'h00, 1'b1);
        look("ee_next", 4'b0100, 8'hA2, 1'b0);

        // Full for 4 cycles after word 2; the remaining 6 words follow
        do_reset();
        req      = 4'b0010;
        req_lock = 4'b0010;
        look("fm_w1", 4'b0010, 8'hA1, 1'b0);
        look("fm_w2", 4'b0010, 8'hA1, 1'b1);
        wfull = 1'b1;
        for (int c = 0; c < 4; c++) begin
            look("fm_full", 4'b0000, 8'h00, 1'b1);
        end
        wfull = 1'b0;
        for (int w = 3; w <= 8; w++) begin
            look("fm_w", 4'b0010, 8'hA1, 1'b1);
        end
        req = 4'b0000;
        look("fm_end", 4'b0000, 8'h00, 1'b0);

        // Reset during a burst with three words written
        do_reset();
        req      = 4'b0010;
        req_lock = 4'b0010;
        look("rb_w1", 4'b0010, 8'hA1, 1'b0);
        look("rb_w2", 4'b0010, 8'hA1, 1'b1);
        look("rb_w3", 4'b0010, 8'hA1, 1'b1);
        rst      = 1'b1;
        req      = 4'b1111;
        req_lock = 4'b0000;
        look("rb_rst", 4'b0000, 8'h00, 1'b1);
        rst = 1'b0;
        look("rb_after", 4'b0001, 8'hA0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
